instruction_fetch_controller: RTL and testbench
===============================================

INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: program counter value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 SHALL provide parameter DEPTH, default 2: instruction buffer entries; legal values are 2 and 4 only.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 ImemAddress  output  32  fetch address driven to the instruction ROM.
REQ-006 ImemInstruction  input  32  ROM read data; combinational from ImemAddress, same cycle.
REQ-007 InstrValid  output  1  buffer head holds a valid instruction.
REQ-008 InstrReady  input  1  decode accepts the head instruction.
REQ-009 Instruction  output  32  head instruction word.
REQ-010 InstrPc  output  32  address the head instruction was fetched from.
REQ-011 RedirectValid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-012 RedirectTarget  input  32  redirect destination address.
REQ-013 Halt  input  1  suspend fetching while high.
REQ-014 BufCount  output  3  number of occupied buffer entries, 0..DEPTH.

Function
REQ-015 ImemAddress SHALL equal the PC register combinationally.
REQ-016 A push SHALL occur on a rising edge when RedirectValid=0, Halt=0, and either BufCount<DEPTH or a pop occurs in the same cycle.
REQ-017 A push SHALL write {PC, ImemInstruction} at the buffer tail and advance PC by 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 A pop SHALL occur when InstrValid=1 and InstrReady=1, removing the head entry.
REQ-019 InstrValid SHALL be 1 exactly when BufCount>0; Instruction and InstrPc SHALL be 32'h0 when BufCount=0.
REQ-020 Instruction and InstrPc SHALL hold stable while InstrValid=1 and InstrReady=0.
REQ-021 Buffer order SHALL be FIFO: no instruction dropped, duplicated or reordered, except on redirect.
REQ-022 Fetch latency SHALL be one cycle: a word pushed at edge N is visible on Instruction after edge N.
REQ-023 Simultaneous push and pop SHALL leave BufCount unchanged; with the buffer full, a pop SHALL enable a push in the same cycle.
REQ-024 RedirectValid=1 SHALL take priority: on that edge, BufCount <- 0, PC <- {RedirectTarget[31:2], 2'b00}, and no push.
REQ-025 A pop in the same cycle as a redirect SHALL count as delivered, and the flush SHALL still discard all entries.
REQ-026 Halt=1 without redirect SHALL hold PC and inhibit pushes, while pops continue so the buffer drains.
REQ-027 Redirect while Halt=1 SHALL update PC and flush per REQ-024; fetching resumes from the new PC when Halt falls.
REQ-028 Pointer and count arithmetic SHALL wrap modulo DEPTH, with BufCount never exceeding DEPTH or going below 0.

Reset
REQ-029 ResetN=0 SHALL immediately, without a clock edge, force PC=RESET_PC, BufCount=0, InstrValid=0, Instruction=0 and InstrPc=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-031 The first push SHALL occur on the first rising edge with ResetN=1.

Verification
REQ-032 Reset release with Ready=1 and the standard test ROM -> consecutive cycles show Instruction/InstrPc = 00432020/0, 8c440004/4, ac450008/8, one per cycle.
REQ-033 Ready=0 for 5 cycles after reset -> BufCount saturates at 2, ImemAddress holds 0x8, Instruction holds 00432020; when Ready=1 the sequence continues at 8c440004 with no gap or duplicate.
REQ-034 Buffer full, RedirectValid=1 with target 0x1D -> next cycle InstrValid=0, BufCount=0, ImemAddress=0x1C; the following cycle gives Instruction=10630001 with InstrPc=0x1C.
REQ-035 Halt=1 with 2 entries buffered and Ready=1 -> two pops, then InstrValid=0 while ImemAddress stays constant; Halt=0 resumes fetching from the held PC.
REQ-036 ResetN pulsed low between clock edges with a full buffer -> InstrValid=0 and ImemAddress=RESET_PC before the next edge.
REQ-037 RESET_PC=32'hFFFF_FFFC -> InstrPc sequence is FFFFFFFC, 00000000, 00000004.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// instruction_fetch_controller
//
// Keeps a program counter, reads one word per cycle from a combinational
// instruction ROM, and queues {pc, instruction} pairs in a small FIFO that the
// decode stage drains with a valid/ready handshake. A redirect reloads the PC
// and flushes the FIFO. Halt freezes fetching while decode keeps draining.
//
// Parameters
//   RESET_PC  PC loaded on reset (word aligned)
//   DEPTH     FIFO entries, 2 or 4
//
// Ports
//   Clock            rising-edge clock
//   ResetN           asynchronous active-low reset
//   ImemAddress      fetch address to the ROM (the PC)
//   ImemInstruction  ROM data for ImemAddress, same cycle
//   InstrValid       FIFO head holds an instruction
//   InstrReady       decode accepts the head this cycle
//   Instruction      head instruction word (0 when empty)
//   InstrPc          head instruction address (0 when empty)
//   RedirectValid    one-cycle redirect pulse
//   RedirectTarget   redirect destination
//   Halt             suspend fetching while high
//   BufCount         occupied FIFO entries, 0..DEPTH
// -----------------------------------------------------------------------------
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        Clock,
    input  logic        ResetN,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPc,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        Halt,
    output logic [2:0]  BufCount
);

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
    localparam int         PTR_W     = (DEPTH == 4) ? 2 : 1;
    localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);

    generate
        if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
            $error("instruction_fetch_controller: DEPTH must be 2 or 4");
        end
    endgenerate

    logic [31:0]      pc_reg, pc_next;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [2:0]       count_reg, count_next;

    // Entry storage needs no reset: it is only visible while count_reg > 0,
    // and every visible entry has been written by a push first.
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] addr_mem  [DEPTH];

    logic pop;
    logic push;

    // A pop alongside a redirect still counts as delivered; the flush
    // below simply discards whatever remains.
    assign pop  = (count_reg != 3'd0) && InstrReady;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push = !RedirectValid && !Halt && ((count_reg < DEPTH_CNT) || pop);

    always_comb begin
        pc_next    = pc_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (RedirectValid) begin
            pc_next    = {RedirectTarget[31:2], 2'b00};
            head_next  = '0;
            tail_next  = '0;
            count_next = 3'd0;
        end else begin
            if (push) begin
                pc_next   = pc_reg + 32'd4;
                tail_next = tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_next = head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 3'd1;
                2'b01:   count_next = count_reg - 3'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pc_reg    <= RESET_PC;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 3'd0;
        end else begin
            pc_reg    <= pc_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            instr_mem[tail_reg] <= ImemInstruction;
            addr_mem[tail_reg]  <= pc_reg;
        end
    end

    assign ImemAddress = pc_reg;
    assign BufCount    = count_reg;
    assign InstrValid  = (count_reg != 3'd0);
    assign Instruction = InstrValid ? instr_mem[head_reg] : 32'h0;
    assign InstrPc     = InstrValid ? addr_mem[head_reg]  : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_controller
//
// Directed bench. The stimulus process drives inputs one time unit after each
// rising edge and pushes expected deliveries into a scoreboard queue, plus
// point observations into a probe queue. The monitor process, on each falling
// edge, settles the probes and compares every handshake (InstrValid and
// InstrReady both high) against the scoreboard head.
// A second instance with RESET_PC = FFFFFFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_controller;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [31:0] InstrPc;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        Halt;
    logic [2:0]  BufCount;

    // Wrap-around instance: always ready, never redirected or halted.
    logic [31:0] imem_address2;
    logic [31:0] imem_instruction2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic [31:0] instruction2;
    logic [31:0] instr_pc2;
    logic        redirect_valid2;
    logic [31:0] redirect_target2;
    logic        halt2;
    logic [2:0]  buf_count2;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    string       probe_name_q[$];
    logic [31:0] probe_act_q[$];
    logic [31:0] probe_exp_q[$];
    logic        finish_req = 1'b0;
    logic        mon_done   = 1'b0;

    always #5 Clock = ~Clock;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0043_2020;
            32'h0000_0004: rom = 32'h8c44_0004;
            32'h0000_0008: rom = 32'hac45_0008;
            32'h0000_000C: rom = 32'h00a6_3020;
            32'h0000_0010: rom = 32'h0109_5024;
            32'h0000_001C: rom = 32'h1063_0001;
            default:       rom = 32'hC0DE_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    always_comb ImemInstruction   = rom(ImemAddress);
    always_comb imem_instruction2 = rom(imem_address2);

    instruction_fetch_controller #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .Clock          (Clock),
        .ResetN         (ResetN),
        .ImemAddress    (ImemAddress),
        .ImemInstruction(ImemInstruction),
        .InstrValid     (InstrValid),
        .InstrReady     (InstrReady),
        .Instruction    (Instruction),
        .InstrPc        (InstrPc),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .Halt           (Halt),
        .BufCount       (BufCount)
    );

    instruction_fetch_controller #(
        .RESET_PC(32'hFFFF_FFFC),
        .DEPTH   (2)
    ) dut_wrap (
        .Clock          (Clock),
        .ResetN         (ResetN),
        .ImemAddress    (imem_address2),
        .ImemInstruction(imem_instruction2),
        .InstrValid     (instr_valid2),
        .InstrReady     (instr_ready2),
        .Instruction    (instruction2),
        .InstrPc        (instr_pc2),
        .RedirectValid  (redirect_valid2),
        .RedirectTarget (redirect_target2),
        .Halt           (halt2),
        .BufCount       (buf_count2)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_txn(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic probe(input string name, input logic [31:0] act, input logic [31:0] expv);
        probe_name_q.push_back(name);
        probe_act_q.push_back(act);
        probe_exp_q.push_back(expv);
    endtask

    // Monitor / scoreboard: the only process that updates checks and errors.
    initial begin
        logic [63:0] e;
        logic [31:0] pa;
        logic [31:0] pe;
        string       pn;
        int          txn = 0;
        forever begin
            @(negedge Clock);
            while (probe_name_q.size() > 0) begin
                pn = probe_name_q.pop_front();
                pa = probe_act_q.pop_front();
                pe = probe_exp_q.pop_front();
                checks++;
                if (pa !== pe) begin
                    errors++;
                    $display("FAIL %s actual=%08h required=%08h", pn, pa, pe);
                end
            end
            if (ResetN === 1'b1 && InstrValid === 1'b1 && InstrReady === 1'b1) begin
                checks++;
                txn++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn%0d unexpected delivery pc=%08h instr=%08h required=none",
                             txn, InstrPc, Instruction);
                end else begin
                    e = exp_q.pop_front();
                    if ({InstrPc, Instruction} !== e) begin
                        errors++;
                        $display("FAIL txn%0d actual pc=%08h instr=%08h required pc=%08h instr=%08h",
                                 txn, InstrPc, Instruction, e[63:32], e[31:0]);
                    end else begin
                        $display("txn%0d pc=%08h instr=%08h ok", txn, InstrPc, Instruction);
                    end
                end
            end
            if (finish_req && !mon_done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL undelivered actual=%0d entries required=0", exp_q.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    initial begin
        ResetN           = 1'b1;
        InstrReady       = 1'b0;
        RedirectValid    = 1'b0;
        RedirectTarget   = 32'h0;
        Halt             = 1'b0;
        instr_ready2     = 1'b1;
        redirect_valid2  = 1'b0;
        redirect_target2 = 32'h0;
        halt2            = 1'b0;
        #1 ResetN = 1'b0;
        #1;
        probe("rst_valid", {31'h0, InstrValid}, 32'h0);
        probe("rst_count", {29'h0, BufCount}, 32'h0);
        probe("rst_instr", Instruction, 32'h0);
        probe("rst_pc", InstrPc, 32'h0);
        probe("rst_addr", ImemAddress, 32'h0);
        probe("rst_addr_wrap", imem_address2, 32'hFFFF_FFFC);
        tick();
        tick();

        // Reset release with Ready=1: one instruction per cycle.
        ResetN     = 1'b1;
        InstrReady = 1'b1;
        expect_txn(32'h0, 32'h0043_2020);
        expect_txn(32'h4, 32'h8c44_0004);
        expect_txn(32'h8, 32'hac45_0008);
        tick();
        probe("first_instr", Instruction, 32'h0043_2020);
        probe("first_pc", InstrPc, 32'h0);
        probe("wrap_pc0", instr_pc2, 32'hFFFF_FFFC);
        tick();
        probe("seq_instr1", Instruction, 32'h8c44_0004);
        probe("seq_pc1", InstrPc, 32'h4);
        probe("wrap_pc1", instr_pc2, 32'h0000_0000);
        tick();
        probe("seq_instr2", Instruction, 32'hac45_0008);
        probe("seq_pc2", InstrPc, 32'h8);
        probe("wrap_pc2", instr_pc2, 32'h0000_0004);
        tick();

        // Mid-operation reset discards the buffer.
        InstrReady = 1'b0;
        ResetN     = 1'b0;
        #1;
        probe("midrst_valid", {31'h0, InstrValid}, 32'h0);
        probe("midrst_count", {29'h0, BufCount}, 32'h0);
        probe("midrst_addr", ImemAddress, 32'h0);
        tick();

        // Ready low for 5 cycles: buffer saturates, then drains in order.
        ResetN = 1'b1;
        expect_txn(32'h0, 32'h0043_2020);
        expect_txn(32'h4, 32'h8c44_0004);
        expect_txn(32'h8, 32'hac45_0008);
        tick();
        tick();
        probe("sat_count_a", {29'h0, BufCount}, 32'd2);
        probe("sat_addr_a", ImemAddress, 32'h8);
        tick();
        tick();
        tick();
        probe("sat_count_b", {29'h0, BufCount}, 32'd2);
        probe("sat_addr_b", ImemAddress, 32'h8);
        probe("sat_instr", Instruction, 32'h0043_2020);
        probe("sat_pc", InstrPc, 32'h0);
        InstrReady = 1'b1;
        tick();
        probe("fullpop_count", {29'h0, BufCount}, 32'd2);
        probe("fullpop_instr", Instruction, 32'h8c44_0004);
        probe("fullpop_pc", InstrPc, 32'h4);
        probe("fullpop_addr", ImemAddress, 32'hC);
        tick();
        tick();

        // Redirect with a full buffer, unaligned target.
        InstrReady = 1'b0;
        probe("prered_count", {29'h0, BufCount}, 32'd2);
        RedirectValid  = 1'b1;
        RedirectTarget = 32'h0000_001D;
        tick();
        RedirectValid = 1'b0;
        probe("redir_valid", {31'h0, InstrValid}, 32'h0);
        probe("redir_count", {29'h0, BufCount}, 32'h0);
        probe("redir_addr", ImemAddress, 32'h1C);
        tick();
        probe("redir_instr", Instruction, 32'h1063_0001);
        probe("redir_pc", InstrPc, 32'h1C);
        tick();

        // Halt with two entries buffered: drain, PC held, then resume.
        probe("prehalt_count", {29'h0, BufCount}, 32'd2);
        Halt       = 1'b1;
        InstrReady = 1'b1;
        expect_txn(32'h1C, 32'h1063_0001);
        expect_txn(32'h20, 32'hC0DE_0020);
        tick();
        tick();
        probe("halt_valid", {31'h0, InstrValid}, 32'h0);
        probe("halt_addr_a", ImemAddress, 32'h24);
        tick();
        probe("halt_addr_b", ImemAddress, 32'h24);
        probe("halt_count", {29'h0, BufCount}, 32'h0);
        Halt = 1'b0;
        expect_txn(32'h24, 32'hC0DE_0024);
        tick();

        // Redirect in the same cycle as a pop: the pop is delivered.
        RedirectValid  = 1'b1;
        RedirectTarget = 32'h0000_0040;
        tick();
        RedirectValid = 1'b0;
        probe("popred_count", {29'h0, BufCount}, 32'h0);
        probe("popred_valid", {31'h0, InstrValid}, 32'h0);
        probe("popred_addr", ImemAddress, 32'h40);
        expect_txn(32'h40, 32'hC0DE_0040);
        tick();

        // Redirect while halted: PC moves, fetch resumes when Halt falls.
        Halt = 1'b1;
        tick();
        probe("hred_pre_addr", ImemAddress, 32'h44);
        RedirectValid  = 1'b1;
        RedirectTarget = 32'h0000_0080;
        tick();
        RedirectValid = 1'b0;
        probe("hred_addr_a", ImemAddress, 32'h80);
        probe("hred_count_a", {29'h0, BufCount}, 32'h0);
        tick();
        probe("hred_addr_b", ImemAddress, 32'h80);
        probe("hred_count_b", {29'h0, BufCount}, 32'h0);
        Halt = 1'b0;
        expect_txn(32'h80, 32'hC0DE_0080);
        tick();
        tick();
        InstrReady = 1'b0;
        tick();
        probe("prerst_count", {29'h0, BufCount}, 32'd2);

        // Asynchronous reset between edges with a full buffer.
        #2 ResetN = 1'b0;
        #1;
        probe("async_valid", {31'h0, InstrValid}, 32'h0);
        probe("async_addr", ImemAddress, 32'h0);
        probe("async_count", {29'h0, BufCount}, 32'h0);
        probe("async_instr", Instruction, 32'h0);
        probe("async_pc", InstrPc, 32'h0);
        probe("async_addr_wrap", imem_address2, 32'hFFFF_FFFC);
        tick();
        tick();
        ResetN = 1'b1;
        tick();
        probe("post_count", {29'h0, BufCount}, 32'd1);
        probe("post_pc", InstrPc, 32'h0);
        tick();

        finish_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) begin
            @(posedge Clock);
        end
        if (!mon_done) begin
            $display("FAIL monitor_done actual=0 required=1");
            $fatal(1, "monitor did not finish");
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
